// File: rtl/instr_queue_if.sv
// Handshake bundle between fetch, the instruction queue and decode.
// master = fetch/decode side, slave = the queue itself.
interface instr_queue_if #(
    parameter int CW = 3
);
    logic          flush;
    logic          push_valid;
    logic          push_ready;
    logic [31:0]   push_instr;
    logic [31:0]   push_pc;
    logic          out_valid;
    logic          pop;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
    logic [5:0]    op;
    logic [5:0]    fn;
    logic [CW-1:0] count;

    modport master (
        output flush, push_valid, push_instr, push_pc, pop,
        input  push_ready, out_valid, out_instr, out_pc, op, fn, count
    );

    modport slave (
        input  flush, push_valid, push_instr, push_pc, pop,
        output push_ready, out_valid, out_instr, out_pc, op, fn, count
    );
endinterface

// File: rtl/instr_queue.sv
// In-order {pc, instr} queue between fetch and decode; circular buffer with
// registered occupancy, flush-to-empty, and zeroed head outputs when empty.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clock,
    input  logic          reset,
    instr_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count_r;
    logic          push_fire;
    logic          pop_fire;
    logic [63:0]   head_entry;

    // Ready/valid come only from the registered count, never from inputs.
    assign q.push_ready = (count_r != FULL);
    assign q.out_valid  = (count_r != '0);

    assign push_fire = q.push_valid & q.push_ready & ~q.flush;
    assign pop_fire  = q.pop & q.out_valid & ~q.flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp      <= '0;
            rp      <= '0;
            count_r <= '0;
        end else if (q.flush) begin
            wp      <= '0;
            rp      <= '0;
            count_r <= '0;
        end else begin
            if (push_fire)
                wp <= wp + 1'b1;
            if (pop_fire)
                rp <= rp + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage is never cleared; the empty-masking below hides stale entries.
    always_ff @(posedge clock) begin
        if (push_fire)
            mem[wp] <= {q.push_pc, q.push_instr};
    end

    assign head_entry  = mem[rp];
    assign q.out_instr = q.out_valid ? head_entry[31:0]  : '0;
    assign q.out_pc    = q.out_valid ? head_entry[63:32] : '0;
    assign q.op        = q.out_instr[31:26];
    assign q.fn        = q.out_instr[5:0];
    assign q.count     = count_r;
endmodule

// File: tb/tb_instr_queue.sv
// Directed bench for instr_queue: ordering, full/empty boundaries, flush,
// and asynchronous reset, with hand-computed expectations.
module tb_instr_queue;
    logic clock;
    logic reset;
    int   checks;
    int   errors;

    instr_queue_if #(.CW(3)) q ();

    instr_queue #(.DEPTH(4), .CW(3)) dut (
        .clock (clock),
        .reset (reset),
        .q     (q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        q.flush = 1'b0;
        q.push_valid = 1'b0;
        q.push_instr = '0;
        q.push_pc = '0;
        q.pop = 1'b0;

        // reset state while reset is held
        #12;
        chk("rst_count", 32'(q.count), 0);
        chk("rst_ready", 32'(q.push_ready), 1);
        chk("rst_valid", 32'(q.out_valid), 0);
        chk("rst_instr", q.out_instr, 0);
        chk("rst_pc", q.out_pc, 0);
        chk("rst_opfn", {20'd0, q.op, q.fn}, 0);
        tick();
        reset = 1'b0;

        // three pushes, no pops
        q.push_valid = 1'b1;
        q.push_instr = 32'h0085_1020; q.push_pc = 32'h0;
        tick();
        chk("p1_count", 32'(q.count), 1);
        chk("p1_instr", q.out_instr, 32'h0085_1020);
        q.push_instr = 32'h8C43_0004; q.push_pc = 32'h4;
        tick();
        q.push_instr = 32'hAC43_0008; q.push_pc = 32'h8;
        tick();
        q.push_valid = 1'b0;
        chk("p3_count", 32'(q.count), 3);
        chk("p3_op", 32'(q.op), 32'h00);
        chk("p3_fn", 32'(q.fn), 32'h20);
        chk("p3_pc", q.out_pc, 32'h0);

        q.pop = 1'b1;
        tick();
        chk("pop1_op", 32'(q.op), 32'h23);
        chk("pop1_fn", 32'(q.fn), 32'h04);
        chk("pop1_pc", q.out_pc, 32'h4);
        tick();
        chk("pop2_op", 32'(q.op), 32'h2B);
        chk("pop2_pc", q.out_pc, 32'h8);
        tick();
        q.pop = 1'b0;
        chk("pop3_valid", 32'(q.out_valid), 0);
        chk("pop3_instr", q.out_instr, 0);
        chk("pop3_opfn", {20'd0, q.op, q.fn}, 0);
        chk("pop3_count", 32'(q.count), 0);

        // fill to DEPTH; pointers start at 3 so the fill wraps
        q.push_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            q.push_pc = 32'h100 + 32'(4 * i);
            q.push_instr = 32'h2000_0000 + q.push_pc;
            tick();
        end
        chk("full_count", 32'(q.count), 4);
        chk("full_ready", 32'(q.push_ready), 0);
        chk("full_head", q.out_pc, 32'h100);
        // push while full plus pop: push rejected
        q.push_pc = 32'h110; q.push_instr = 32'h2000_0110;
        q.pop = 1'b1;
        tick();
        chk("fullpop_count", 32'(q.count), 3);
        chk("fullpop_head", q.out_pc, 32'h104);
        chk("fullpop_ready", 32'(q.push_ready), 1);
        q.pop = 1'b0;
        tick();
        chk("refill_count", 32'(q.count), 4);
        q.push_valid = 1'b0;
        q.pop = 1'b1;
        tick();
        chk("drain1_pc", q.out_pc, 32'h108);
        tick();
        chk("drain2_pc", q.out_pc, 32'h10C);
        tick();
        chk("drain3_pc", q.out_pc, 32'h110);
        chk("drain3_instr", q.out_instr, 32'h2000_0110);
        tick();
        chk("drain4_count", 32'(q.count), 0);
        chk("drain4_valid", 32'(q.out_valid), 0);
        q.pop = 1'b0;

        // steady push+pop at count 2 for 10 cycles
        q.push_valid = 1'b1;
        q.push_pc = 32'h200; q.push_instr = 32'h0000_0200;
        tick();
        q.push_pc = 32'h204; q.push_instr = 32'h0000_0204;
        tick();
        chk("pp_start_count", 32'(q.count), 2);
        chk("pp_start_head", q.out_pc, 32'h200);
        q.pop = 1'b1;
        for (int i = 0; i < 10; i++) begin
            q.push_pc = 32'h208 + 32'(4 * i);
            q.push_instr = q.push_pc;
            tick();
            chk("pp_count", 32'(q.count), 2);
            chk("pp_head", q.out_pc, 32'h204 + 32'(4 * i));
        end
        q.pop = 1'b0;

        // count 3, then flush with push and pop asserted
        q.push_pc = 32'h230; q.push_instr = 32'h0000_0230;
        tick();
        chk("pre_flush_count", 32'(q.count), 3);
        q.flush = 1'b1;
        q.pop = 1'b1;
        q.push_pc = 32'h300; q.push_instr = 32'h0000_0300;
        tick();
        q.flush = 1'b0;
        q.pop = 1'b0;
        chk("flush_count", 32'(q.count), 0);
        chk("flush_valid", 32'(q.out_valid), 0);
        chk("flush_instr", q.out_instr, 0);
        chk("flush_pc", q.out_pc, 0);
        chk("flush_opfn", {20'd0, q.op, q.fn}, 0);
        q.push_pc = 32'h400; q.push_instr = 32'h2400_0400;
        tick();
        q.push_valid = 1'b0;
        chk("postflush_count", 32'(q.count), 1);
        chk("postflush_pc", q.out_pc, 32'h400);
        chk("postflush_op", 32'(q.op), 32'h09);

        // pop while empty
        q.pop = 1'b1;
        tick();
        chk("empty_count0", 32'(q.count), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("empty_pop_count", 32'(q.count), 0);
            chk("empty_pop_valid", 32'(q.out_valid), 0);
        end
        q.pop = 1'b0;
        q.push_valid = 1'b1;
        q.push_pc = 32'h500; q.push_instr = 32'h0000_0500;
        tick();
        q.push_valid = 1'b0;
        chk("after_empty_pc", q.out_pc, 32'h500);
        chk("after_empty_count", 32'(q.count), 1);
        q.pop = 1'b1;
        tick();
        q.pop = 1'b0;
        chk("after_empty_drain", 32'(q.count), 0);

        // asynchronous reset mid-cycle at count 2
        q.push_valid = 1'b1;
        q.push_pc = 32'h600; q.push_instr = 32'h0000_0600;
        tick();
        q.push_pc = 32'h604; q.push_instr = 32'h0000_0604;
        tick();
        q.push_valid = 1'b0;
        chk("prereset_count", 32'(q.count), 2);
        #2;
        reset = 1'b1;
        #1;
        chk("areset_count", 32'(q.count), 0);
        chk("areset_valid", 32'(q.out_valid), 0);
        chk("areset_instr", q.out_instr, 0);
        chk("areset_pc", q.out_pc, 0);
        chk("areset_ready", 32'(q.push_ready), 1);
        #2;
        reset = 1'b0;
        tick();
        chk("postreset_count", 32'(q.count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
